// File: rtl/pdm_dac_pkg.sv
// pdm_dac_pkg: width helpers shared by the PDM-to-DAC bridge.
//   sample_w(d)    : CIC2 sample / integrator width for decimation 2^d (2*d+1)
//   frac_w(d, w)   : bits dropped when requantising to a w-bit DAC
//   r_sq(d)        : R^2, the full-scale decimated value
package pdm_dac_pkg;

  function automatic int sample_w(input int decim_log2);
    return 2 * decim_log2 + 1;
  endfunction

  function automatic int frac_w(input int decim_log2, input int dac_w);
    return 2 * decim_log2 - dac_w;
  endfunction

  function automatic int r_sq(input int decim_log2);
    return 1 << (2 * decim_log2);
  endfunction

  // Full-scale value for the default R=16 build; the clamp limit is one less.
  localparam int DEF_DECIM_LOG2 = 4;
  localparam int DEF_R_SQ       = r_sq(DEF_DECIM_LOG2);

endpackage

// File: rtl/cic2_decim.sv
// cic2_decim: one channel of the bridge -- two integrators, one comb, clamp.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   ce           integrate this cycle's PDM bit
//   frame_end    ce cycle that completes a decimation frame
//   comb_go      run the comb step this cycle (one cycle after frame_end)
//   pdm          PDM bit (1 -> +1, 0 -> 0)
//   sample       decimated sample, modulo 2^SW, unsigned
//   held         clamped sample, top KEEP_W bits of min(y, 2^(2*DECIM_LOG2)-1)
module cic2_decim
  import pdm_dac_pkg::*;
#(
  parameter int DECIM_LOG2 = 4,
  parameter int KEEP_W     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ce,
  input  logic                            frame_end,
  input  logic                            comb_go,
  input  logic                            pdm,
  output logic [sample_w(DECIM_LOG2)-1:0] sample,
  output logic [KEEP_W-1:0]               held
);
  localparam int SW = sample_w(DECIM_LOG2);
  localparam int CW = 2 * DECIM_LOG2;

  logic [SW-1:0] i1, i2, i1_nx, i2_nx;
  logic [SW-1:0] comb_in, d1, d2, c1, y;

  // Integrators wrap freely; the comb difference recovers the true value.
  always_comb begin
    i1_nx = i1 + SW'(pdm);
    i2_nx = i2 + i1_nx;
    c1    = comb_in - d1;
    y     = c1 - d2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i1      <= '0;
      i2      <= '0;
      comb_in <= '0;
      d1      <= '0;
      d2      <= '0;
      sample  <= '0;
      held    <= '0;
    end else begin
      if (ce) begin
        i1 <= i1_nx;
        i2 <= i2_nx;
        if (frame_end) comb_in <= i2_nx;
      end
      if (comb_go) begin
        d1     <= comb_in;
        d2     <= c1;
        sample <= y;
        // y only reaches 2^CW (MSB set) at full scale; saturate it to all-ones.
        held   <= y[SW-1] ? '1 : y[CW-1 -: KEEP_W];
      end
    end
  end

endmodule

// File: rtl/pdm_dac_bridge.sv
// pdm_dac_bridge: multi-channel 1-bit PDM to resistor-ladder DAC bridge.
// Each channel runs a 2nd-order CIC decimator (R = 2^DECIM_LOG2); the
// decimated value is clamped and requantised to DAC_W bits.
// Ports:
//   clk           pixel clock
//   rst           synchronous active-high reset
//   ce_in         PDM sample enable
//   pdm_in        one PDM bit per channel
//   sample_valid  one-cycle pulse with each new set of samples
//   sample_out    decimated samples, channel c at [c*SW +: SW]
//   dac_out       DAC drive, channel c at [c*DAC_W +: DAC_W]
// Build option: define PDM_DAC_NOISE_SHAPE_EN for a first-order
// error-feedback requantiser (needs DAC_W < 2*DECIM_LOG2); otherwise dac_out
// is the truncated clamped sample.
module pdm_dac_bridge
  import pdm_dac_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DECIM_LOG2 = 4,
  parameter int DAC_W      = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ce_in,
  input  logic [NUM_CH-1:0]                      pdm_in,
  output logic                                   sample_valid,
  output logic [NUM_CH*sample_w(DECIM_LOG2)-1:0] sample_out,
  output logic [NUM_CH*DAC_W-1:0]                dac_out
);
  localparam int SW = sample_w(DECIM_LOG2);
`ifdef PDM_DAC_NOISE_SHAPE_EN
  localparam int FW     = frac_w(DECIM_LOG2, DAC_W);
  localparam int KEEP_W = 2 * DECIM_LOG2;
`else
  localparam int KEEP_W = DAC_W;
`endif

  logic [DECIM_LOG2-1:0] phase;
  logic                  frame_end;
  logic                  comb_go;

  assign frame_end = ce_in && (phase == '1);

  // comb_go runs independently of ce_in so a finished frame always emerges.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase        <= '0;
      comb_go      <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      if (ce_in) phase <= phase + 1'b1;
      comb_go      <= frame_end;
      sample_valid <= comb_go;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [KEEP_W-1:0] held;

    cic2_decim #(
      .DECIM_LOG2 (DECIM_LOG2),
      .KEEP_W     (KEEP_W)
    ) u_cic (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce_in),
      .frame_end (frame_end),
      .comb_go   (comb_go),
      .pdm       (pdm_in[c]),
      .sample    (sample_out[c*SW +: SW]),
      .held      (held)
    );

`ifdef PDM_DAC_NOISE_SHAPE_EN
    logic [FW-1:0]    e;
    logic [FW:0]      s;
    logic [DAC_W:0]   sum;
    logic [DAC_W-1:0] dac_q;

    // Carry-out of (fraction + error) bumps the DAC code; the residue is
    // fed back so the long-run average tracks the held sample.
    always_comb begin
      s   = {1'b0, held[FW-1:0]} + {1'b0, e};
      sum = {1'b0, held[KEEP_W-1 -: DAC_W]} + {{DAC_W{1'b0}}, s[FW]};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        e     <= '0;
        dac_q <= '0;
      end else if (ce_in) begin
        e     <= s[FW-1:0];
        dac_q <= sum[DAC_W] ? '1 : sum[DAC_W-1:0];
      end
    end

    assign dac_out[c*DAC_W +: DAC_W] = dac_q;
`else
    assign dac_out[c*DAC_W +: DAC_W] = held;
`endif
  end

endmodule
